uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL provide port baud_divisor  input  16  bit period = baud_divisor+1 clk cycles.
REQ-004 SHALL provide port data_bits  input  3  word length code: 0=5, 1=6, 2=7, 3=8 bits; codes 4-7 never start a frame.
REQ-005 SHALL provide port parity_mode  input  2  0=none, 1=odd, 2=even, 3=treated as none.
REQ-006 SHALL provide port two_stop_bits  input  1  1=two stop bits, 0=one.
REQ-007 SHALL provide port tx_enable  input  1  permits new frames to start.
REQ-008 SHALL provide port config_valid  input  1  config fields are legal; 0 blocks new frames.
REQ-009 SHALL provide port fifo_data  input  8  head of TX FIFO (first-word-fall-through); valid whenever fifo_empty=0.
REQ-010 SHALL provide port fifo_empty  input  1  TX FIFO empty flag.
REQ-011 SHALL provide port fifo_read  output  1  one-cycle pop strobe to TX FIFO.
REQ-012 SHALL provide port tx_out  output  1  serial line; idle high.
REQ-013 SHALL provide port tx_busy  output  1  high whenever state != IDLE.
REQ-014 SHALL provide port tx_ready  output  1  high when state==IDLE, tx_enable=1, config_valid=1.
REQ-015 SHALL provide port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE, when tx_ready=1 and fifo_empty=0, SHALL assert fifo_read for exactly one cycle, capture fifo_data, latch baud_divisor/data_bits/parity_mode/two_stop_bits that same cycle, and move to START.
REQ-018 tx_out SHALL fall to 0 in the cycle after fifo_read (latency 1) and hold each bit exactly baud_divisor+1 cycles; baud_divisor=0 gives 1-cycle bits.
REQ-019 DATA SHALL send the latched word LSB first, n bits (n=5..8); bits above n SHALL be neither sent nor included in parity.
REQ-020 PARITY SHALL be entered only for modes 1/2: even bit = XOR of the n data bits; odd bit = its inverse; modes 0/3 go DATA->STOP.
REQ-021 STOP SHALL drive 1 for one or two bit periods per latched two_stop_bits, then return to IDLE.
REQ-022 tx_done SHALL pulse in the first IDLE cycle after STOP; fifo_read MAY assert in that same cycle, giving exactly one extra high cycle between back-to-back frames.
REQ-023 Input config changes, tx_enable or config_valid dropping mid-frame SHALL not affect the frame in progress; the frame completes, no new one starts.
REQ-024 fifo_read SHALL never assert when fifo_empty=1 or state != IDLE.
REQ-025 Bit-period counter SHALL be 16 bits, count down from latched divisor, reload at each bit boundary, no wrap artefacts at 0xFFFF.
REQ-026 Total frame length SHALL be (1+n+p+s)*(baud_divisor+1) cycles, p in {0,1}, s in {1,2}.

Reset
REQ-027 While reset=1: state=IDLE, tx_out=1, fifo_read=0, tx_done=0, tx_busy=0, counters and shift register 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; tx_out=1 from the cycle after the reset edge, without tx_done; the popped byte is not retransmitted.
REQ-029 tx_ready SHALL be 0 during reset and may rise the first cycle after reset deasserts.

Verification
REQ-030 8N1, divisor=3, FIFO holds 0xA5 -> one fifo_read; tx_out = 0,1,0,1,0,0,1,0,1,1 each 4 cycles (40 cycles); tx_done one cycle after.
REQ-031 7E1 (data_bits=2, parity=2), divisor=0, byte 0xD3 -> data 1,1,0,0,1,0,1 (bit 7 dropped), parity 0, stop 1; 10-cycle frame.
REQ-032 5O2 (data_bits=0, parity=1, two_stop=1), byte 0xFF -> five 1s, parity 0, two stop bits; frame 9 bit periods.
REQ-033 FIFO with 0x11,0x22, 8N1, divisor=1 -> two frames, exactly one idle-high cycle between, two fifo_read and two tx_done pulses.
REQ-034 Reset pulse in DATA bit 3 -> tx_out=1 next cycle, tx_busy=0, no tx_done; clear tx_enable mid-frame -> frame finishes, no further fifo_read.
REQ-035 config_valid=0 or data_bits=5 with fifo_empty=0 -> tx_ready=0, fifo_read never asserts, tx_out stays 1.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from a first-word-fall-through FIFO and serialises
// them as start / 5-8 data bits LSB first / optional parity / one or two stop bits.
module uart_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] baud_divisor,
    input  logic [2:0]  data_bits,
    input  logic [1:0]  parity_mode,
    input  logic        two_stop_bits,
    input  logic        tx_enable,
    input  logic        config_valid,
    input  logic [7:0]  fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_read,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        tx_ready,
    output logic        tx_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t      state, state_nx;
    logic [15:0] div_q, baud_cnt;
    logic [2:0]  last_bit, bit_cnt;
    logic [7:0]  shreg, dmask;
    logic        par_en, par_bit, stop2_q, stop_cnt, done_q;
    logic        bit_end, line;

    assign bit_end  = (baud_cnt == 16'd0);
    // Keeps only the n data bits of the word when computing parity.
    assign dmask    = 8'hFF >> (2'd3 - data_bits[1:0]);
    assign tx_ready = !reset && (state == IDLE) && tx_enable && config_valid && !data_bits[2];
    assign tx_busy  = !reset && (state != IDLE);
    assign tx_done  = !reset && done_q;
    assign tx_out   = reset | line;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        fifo_read = 1'b0;
        line      = 1'b1;
        case (state)
            IDLE: if (tx_ready && !fifo_empty) begin
                fifo_read = 1'b1;
                state_nx  = START;
            end
            START: begin
                line = 1'b0;
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                line = shreg[0];
                if (bit_end && bit_cnt == last_bit) state_nx = par_en ? PARITY : STOP;
            end
            PARITY: begin
                line = par_bit;
                if (bit_end) state_nx = STOP;
            end
            STOP: if (bit_end && stop_cnt == stop2_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame parameters are captured with the pop so mid-frame input changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            baud_cnt <= '0;
            last_bit <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop2_q  <= 1'b0;
            stop_cnt <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == STOP) && (state_nx == IDLE);
            if (fifo_read) begin
                div_q    <= baud_divisor;
                baud_cnt <= baud_divisor;
                last_bit <= {1'b1, data_bits[1:0]};
                bit_cnt  <= '0;
                shreg    <= fifo_data;
                par_en   <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                par_bit  <= (^(fifo_data & dmask)) ^ (parity_mode == 2'd1);
                stop2_q  <= two_stop_bits;
                stop_cnt <= 1'b0;
            end else if (state != IDLE) begin
                baud_cnt <= bit_end ? div_q : baud_cnt - 16'd1;
                if (bit_end && state == DATA) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (bit_end && state == STOP) stop_cnt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: a FIFO model pushes the expected line
// waveform of every popped byte; a negedge monitor replays it against tx_out.
module tb_uart_tx;

    logic        clk, reset;
    logic [15:0] baud_divisor;
    logic [2:0]  data_bits;
    logic [1:0]  parity_mode;
    logic        two_stop_bits, tx_enable, config_valid;
    logic [7:0]  fifo_data;
    logic        fifo_empty, fifo_read, tx_out, tx_busy, tx_ready, tx_done;

    uart_tx dut (
        .clk(clk), .reset(reset), .baud_divisor(baud_divisor), .data_bits(data_bits),
        .parity_mode(parity_mode), .two_stop_bits(two_stop_bits), .tx_enable(tx_enable),
        .config_valid(config_valid), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .tx_out(tx_out), .tx_busy(tx_busy), .tx_ready(tx_ready),
        .tx_done(tx_done)
    );

    typedef struct {
        logic [11:0] bits;
        int          nb;
        int          per;
    } frame_t;

    int         vectors = 0, miscompares = 0;
    logic [7:0] fifo_q[$];
    frame_t     exp_q[$];
    frame_t     cur;
    int         bidx, cyc;
    logic       mon_en = 1'b0, active = 1'b0, done_due = 1'b0, bit_bad, in_frame, rdy_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares < 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Line waveform derived from the frame format: start, n data bits, parity, stops.
    function automatic frame_t model(input logic [7:0] d, input int db, input int pm,
                                     input logic s2, input int div);
        frame_t f;
        int n, k, ones;
        n = db + 5; k = 0; ones = 0;
        f.bits = '1;
        f.per = div + 1;
        f.bits[k] = 1'b0; k++;
        for (int i = 0; i < n; i++) begin
            f.bits[k] = d[i]; k++;
            ones += int'(d[i]);
        end
        if (pm == 1 || pm == 2) begin
            f.bits[k] = (pm == 2) ? (ones % 2 == 1) : (ones % 2 == 0); k++;
        end
        f.bits[k] = 1'b1; k++;
        if (s2) begin f.bits[k] = 1'b1; k++; end
        f.nb = k;
        return f;
    endfunction

    function automatic void upd_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        upd_fifo();
    endtask

    task automatic cfg(input int db, input int pm, input int s2, input int div);
        data_bits     = 3'(db);
        parity_mode   = 2'(pm);
        two_stop_bits = 1'(s2);
        baud_divisor  = 16'(div);
    endtask

    // FIFO model: a pop seen before the edge becomes an expected frame after it.
    initial begin
        logic       pop_now;
        frame_t     f;
        forever begin
            @(negedge clk);
            pop_now = (fifo_read === 1'b1) && !reset;
            if (pop_now) f = model(fifo_data, int'(data_bits), int'(parity_mode), two_stop_bits, int'(baud_divisor));
            @(posedge clk); #1;
            if (pop_now) begin
                exp_q.push_back(f);
                void'(fifo_q.pop_front());
                upd_fifo();
            end
        end
    end

    always @(negedge clk) begin
        if (!mon_en) begin
            active   = 1'b0;
            done_due = 1'b0;
        end else begin
            in_frame = 1'b0;
            check("tx_done", tx_done, done_due);
            done_due = 1'b0;
            if (!active && tx_out === 1'b0) begin
                if (exp_q.size() == 0) check("unexpected_start", 1, 0);
                else begin
                    cur = exp_q.pop_front();
                    active = 1'b1; bidx = 0; cyc = 0; bit_bad = 1'b0;
                end
            end
            if (active) begin
                in_frame = 1'b1;
                if (tx_out !== cur.bits[bidx]) bit_bad = 1'b1;
                cyc++;
                if (cyc == cur.per) begin
                    check($sformatf("frame_bit%0d_bad", bidx), bit_bad, 0);
                    bit_bad = 1'b0; cyc = 0; bidx++;
                    if (bidx == cur.nb) begin active = 1'b0; done_due = 1'b1; end
                end
            end
            rdy_exp = !in_frame && tx_enable && config_valid && !data_bits[2];
            check("busy_ready_read", {tx_busy, tx_ready, fifo_read},
                  {in_frame, rdy_exp, rdy_exp && (fifo_q.size() > 0)});
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0 || active || done_due) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", n >= 20000, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_pop();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (fifo_read !== 1'b1 && n < 200);
        check("wait_pop", fifo_read, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; tx_enable = 1'b1; config_valid = 1'b1;
        cfg(3, 0, 0, 3);
        upd_fifo();
        push(8'hA5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_fifo_read", fifo_read, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_done", tx_done, 0);
        check("rst_tx_ready", tx_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0; mon_en = 1'b1;
        drain();                                   // 8N1 div 3, 0xA5

        cfg(2, 2, 0, 0); push(8'hD3); drain();     // 7E1 div 0
        cfg(0, 1, 1, 2); push(8'hFF); drain();     // 5O2
        cfg(3, 0, 0, 1); push(8'h11); push(8'h22); drain();

        // Reset in the middle of data bit 3 aborts without tx_done or retransmit.
        cfg(3, 0, 0, 3); push(8'h3C);
        wait_pop();
        repeat (18) @(posedge clk);
        #1;
        reset = 1'b1; mon_en = 1'b0;
        @(negedge clk);
        check("abort_tx_out", tx_out, 1);
        check("abort_tx_busy", tx_busy, 0);
        check("abort_tx_done", tx_done, 0);
        @(posedge clk); #1;
        reset = 1'b0; exp_q.delete(); mon_en = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        // Dropping tx_enable mid-frame lets the frame finish but holds the next byte.
        cfg(3, 1, 0, 2); push(8'h81); push(8'h7E);
        wait_pop();
        repeat (6) @(posedge clk);
        #1;
        tx_enable = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("enable_hold_fifo", fifo_q.size(), 1);
        tx_enable = 1'b1;
        drain();

        config_valid = 1'b0; push(8'h99);
        repeat (30) @(posedge clk);
        #1;
        check("cfg_invalid_hold", fifo_q.size(), 1);
        config_valid = 1'b1; cfg(5, 0, 0, 0);
        repeat (30) @(posedge clk);
        #1;
        check("bad_bits_hold", fifo_q.size(), 1);
        cfg(3, 0, 0, 0); drain();

        for (int it = 0; it < 80; it++) begin
            @(posedge clk); #1;
            if ($urandom % 3 == 0) push(8'($urandom));
            if ($urandom % 3 == 0)
                cfg(int'($urandom % 5), int'($urandom % 4), int'($urandom % 2), int'($urandom % 4));
            tx_enable    = ($urandom % 8) != 0;
            config_valid = ($urandom % 8) != 0;
            repeat ($urandom % 20) @(posedge clk);
            #1;
        end
        tx_enable = 1'b1; config_valid = 1'b1;
        cfg(int'($urandom % 4), int'($urandom % 4), int'($urandom % 2), int'($urandom % 3));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
